// File: rtl/core_req_issuer_if.sv
// Request/strobe bundle between the execute stage and the per-core request issuer.
// The master side is the execute stage plus the core's stall logic. The slave side is the issuer.
interface core_req_issuer_if;
    logic        req_valid;
    logic [1:0]  req_kind;
    logic [1:0]  req_target;
    logic [15:0] req_pc;
    logic        req_ready;
    logic        hold;
    logic [18:0] pc_out;
    logic [3:0]  pauseResume;
    logic        busy;
    logic        overflow;

    modport master (
        output req_valid, req_kind, req_target, req_pc, hold,
        input  req_ready, pc_out, pauseResume, busy, overflow
    );

    modport slave (
        input  req_valid, req_kind, req_target, req_pc, hold,
        output req_ready, pc_out, pauseResume, busy, overflow
    );
endinterface

// File: rtl/core_req_issuer.sv
// Per-core issuer for inter-core wake/pause/resume requests.
// Requests are queued in a small FIFO and issued in order, one per cycle.
// Each issued request appears as a single-cycle registered strobe on pc_out or pauseResume.
module core_req_issuer #(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    core_req_issuer_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        KIND_WAKE    = 2'd0,
        KIND_PAUSE   = 2'd1,
        KIND_RESUME  = 2'd2,
        KIND_ILLEGAL = 2'd3
    } kind_e;

    typedef struct packed {
        kind_e       kind;
        logic [1:0]  target;
        logic [15:0] pc;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [18:0]      pc_out_q, pc_out_d;
    logic [3:0]       pause_resume_q, pause_resume_d;
    logic             overflow_q, overflow_d;

    logic   full;
    logic   push;
    logic   pop;
    entry_t head;
    entry_t req_entry;

    assign full      = (count_q == FULL_CNT);
    // Illegal kinds are dropped silently. A request offered while full is refused and flagged.
    assign push      = bus.req_valid && !full && (bus.req_kind != KIND_ILLEGAL);
    // The head is only read when count is non-zero, so an entry never bypasses the FIFO.
    assign pop       = (count_q != '0) && !bus.hold;
    assign head      = mem_q[rd_ptr_q];
    assign req_entry = '{kind: kind_e'(bus.req_kind), target: bus.req_target, pc: bus.req_pc};

    // Next-state: pointer/count bookkeeping, head decode into strobes, sticky overflow.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        pc_out_d       = '0;
        pause_resume_d = '0;
        overflow_d     = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            case (head.kind)
                KIND_WAKE:                pc_out_d       = {1'b1, head.target, head.pc};
                KIND_PAUSE, KIND_RESUME:  pause_resume_d = {1'b1, head.kind == KIND_RESUME, head.target};
                default:                  ;
            endcase
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase

        if (bus.req_valid && full) begin
            overflow_d = 1'b1;
        end
    end

    // Control and output registers. Reset clears queue state and strobes at once.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state is assigned with <= so every flop samples pre-edge values regardless of statement order.
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            pc_out_q       <= '0;
            pause_resume_q <= '0;
            overflow_q     <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            pc_out_q       <= pc_out_d;
            pause_resume_q <= pause_resume_d;
            overflow_q     <= overflow_d;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; count and pointers alone define which entries are valid.
        if (push) begin
            mem_q[wr_ptr_q] <= req_entry;
        end
    end

    assign bus.req_ready   = !full;
    assign bus.pc_out      = pc_out_q;
    assign bus.pauseResume = pause_resume_q;
    assign bus.overflow    = overflow_q;
    assign bus.busy        = (count_q != '0) || pc_out_q[18] || pause_resume_q[3];

endmodule

// File: tb/tb_core_req_issuer.sv
// Self-checking bench for core_req_issuer. It uses a directed vector table, hand-written
// multi-cycle sequences, and randomized traffic checked against a queue-based reference model.
module tb_core_req_issuer;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    core_req_issuer_if bus ();

    core_req_issuer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [1:0]  kind;
        logic [1:0]  target;
        logic [15:0] pc;
    } req_t;

    req_t        mq[$];
    bit          m_ovf;
    logic [18:0] m_pc;
    logic [3:0]  m_pr;

    function automatic void model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_pc  = '0;
        m_pr  = '0;
    endfunction

    // One clock edge: issue the oldest request unless held, then accept the new one if there was room.
    function automatic void model_step(input logic v, input logic [1:0] k, input logic [1:0] t,
                                       input logic [15:0] pc, input logic h);
        bit   was_full;
        req_t r;
        req_t n;
        was_full = (mq.size() == DEPTH);
        m_pc = '0;
        m_pr = '0;
        if (mq.size() > 0 && !h) begin
            r = mq.pop_front();
            if (r.kind == 2'd0) m_pc = {1'b1, r.target, r.pc};
            else                m_pr = {1'b1, r.kind == 2'd2, r.target};
        end
        if (v && was_full) begin
            m_ovf = 1'b1;
        end else if (v && k != 2'd3) begin
            n.kind = k; n.target = t; n.pc = pc;
            mq.push_back(n);
        end
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, " pc_out"},      32'(bus.pc_out),      32'(m_pc));
        check({tag, " pauseResume"}, 32'(bus.pauseResume), 32'(m_pr));
        check({tag, " req_ready"},   32'(bus.req_ready),   32'(mq.size() != DEPTH));
        check({tag, " busy"},        32'(bus.busy),        32'(mq.size() != 0 || m_pc[18] || m_pr[3]));
        check({tag, " overflow"},    32'(bus.overflow),    32'(m_ovf));
    endtask

    task automatic drive(input logic v, input logic [1:0] k, input logic [1:0] t,
                         input logic [15:0] pc, input logic h);
        bus.req_valid  = v;
        bus.req_kind   = k;
        bus.req_target = t;
        bus.req_pc     = pc;
        bus.hold       = h;
    endtask

    // Drive inputs, let one edge pass, then compare all outputs against the model 1 ns later.
    task automatic cycle(input logic v, input logic [1:0] k, input logic [1:0] t,
                         input logic [15:0] pc, input logic h, input string tag);
        drive(v, k, t, pc, h);
        @(posedge clk);
        model_step(v, k, t, pc, h);
        #1;
        compare_model(tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 2'd0, 2'd0, 16'h0, 1'b0, tag);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        v;
        logic [1:0]  k;
        logic [1:0]  t;
        logic [15:0] pc;
        logic        h;
        logic [18:0] e_pc;
        logic [3:0]  e_pr;
        logic        e_rdy;
        logic        e_busy;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic        rv, rh;
        logic [1:0]  rk;
        logic [15:0] rpc;

        vecs[0]  = '{1'b0, 2'd0, 2'd0, 16'h0000, 1'b0, 19'h00000, 4'h0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 2'd0, 2'd2, 16'h0040, 1'b0, 19'h00000, 4'h0, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 2'd0, 16'h0000, 1'b0, 19'h60040, 4'h0, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 2'd0, 2'd0, 16'h0000, 1'b0, 19'h00000, 4'h0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 2'd1, 2'd1, 16'h0000, 1'b0, 19'h00000, 4'h0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 2'd2, 2'd1, 16'h0000, 1'b0, 19'h00000, 4'h9, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 2'd0, 2'd3, 16'h1234, 1'b0, 19'h00000, 4'hD, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 2'd0, 2'd0, 16'h0000, 1'b0, 19'h71234, 4'h0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 2'd0, 2'd0, 16'h0000, 1'b0, 19'h00000, 4'h0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 2'd3, 2'd0, 16'hFFFF, 1'b0, 19'h00000, 4'h0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 2'd0, 2'd0, 16'h0000, 1'b0, 19'h00000, 4'h0, 1'b1, 1'b0, 1'b0};

        // Reset state while reset is held.
        reset = 1'b1;
        drive(1'b0, 2'd0, 2'd0, 16'h0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_model("in_reset");
        @(negedge clk);
        reset = 1'b0;

        // Single wake, mixed burst, illegal kind.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].v, vecs[i].k, vecs[i].t, vecs[i].pc, vecs[i].h);
            @(posedge clk);
            model_step(vecs[i].v, vecs[i].k, vecs[i].t, vecs[i].pc, vecs[i].h);
            #1;
            check($sformatf("vec%0d pc_out", i),      32'(bus.pc_out),      32'(vecs[i].e_pc));
            check($sformatf("vec%0d pauseResume", i), 32'(bus.pauseResume), 32'(vecs[i].e_pr));
            check($sformatf("vec%0d req_ready", i),   32'(bus.req_ready),   32'(vecs[i].e_rdy));
            check($sformatf("vec%0d busy", i),        32'(bus.busy),        32'(vecs[i].e_busy));
            check($sformatf("vec%0d overflow", i),    32'(bus.overflow),    32'(vecs[i].e_ovf));
        end

        // Hold mid-stream: 3 queued, one strobe, 3 held cycles, then 2 back-to-back strobes.
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'd0, 2'(i), 16'h0200 + 16'(i), 1'b1, "hm_fill");
        cycle(1'b0, 2'd0, 2'd0, 16'h0, 1'b0, "hm_first");
        check("hm_first_strobe", 32'(bus.pc_out), 32'h40200);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 2'd0, 2'd0, 16'h0, 1'b1, "hm_hold");
            check("hm_hold_quiet", 32'({bus.pc_out, bus.pauseResume}), 32'h0);
        end
        cycle(1'b0, 2'd0, 2'd0, 16'h0, 1'b0, "hm_second");
        check("hm_second_strobe", 32'(bus.pc_out), 32'h50201);
        cycle(1'b0, 2'd0, 2'd0, 16'h0, 1'b0, "hm_third");
        check("hm_third_strobe", 32'(bus.pc_out), 32'h60202);
        drain("hm_drain");

        // Randomized traffic, with hold probability rising across phases so the FIFO fills.
        for (int p = 0; p < 4; p++) begin
            for (int n = 0; n < 100; n++) begin
                rh  = ($urandom_range(0, 99) < p * 25);
                rv  = $urandom_range(0, 1);
                rk  = 2'($urandom_range(0, 3));
                if (rk == 2'd3 && mq.size() == DEPTH) rk = 2'd0;
                rpc = 16'($urandom);
                cycle(rv, rk, 2'($urandom_range(0, 3)), rpc, rh, "rand");
            end
        end
        drain("rand_drain");

        // Reset mid-strobe with 2 entries still queued.
        cycle(1'b1, 2'd0, 2'd1, 16'hABCD, 1'b1, "rst_fill");
        cycle(1'b1, 2'd0, 2'd2, 16'h1111, 1'b1, "rst_fill");
        cycle(1'b1, 2'd0, 2'd3, 16'h2222, 1'b0, "rst_fill");
        check("rst_pre_strobe", 32'(bus.pc_out), 32'h5ABCD);
        drive(1'b0, 2'd0, 2'd0, 16'h0, 1'b0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        compare_model("rst_async");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, 2'd0, 16'h0, 1'b0, "rst_after");

        // Fill and overflow: 5 pushes under hold, then exactly 4 in-order strobes.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 2'd0, 2'(i), 16'h0100 + 16'(i), 1'b1, "ov_fill");
            if (i == 3) check("ov_ready_low", 32'(bus.req_ready), 32'h0);
            if (i == 4) check("ov_flag_set", 32'(bus.overflow), 32'h1);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 2'd0, 2'd0, 16'h0, 1'b0, "ov_drain");
            check($sformatf("ov_strobe%0d", i), 32'(bus.pc_out), 32'({1'b1, 2'(i), 16'h0100 + 16'(i)}));
        end
        cycle(1'b0, 2'd0, 2'd0, 16'h0, 1'b0, "ov_done");
        check("ov_no_fifth", 32'(bus.pc_out), 32'h0);
        check("ov_sticky", 32'(bus.overflow), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
